// File: rtl/bpred_update_scheduler_pkg.sv
// Shared types for the local-history predictor update path: BrInfo record, scheduler state, table index width.
// Also holds the saturating 16-bit add used by the drop counter.
package bpred_update_scheduler_pkg;

    localparam int BPRED_INDEX_W = 15;

    typedef logic [31:0] Addr;

    typedef struct packed {
        logic valid;
        Addr  pc;
        logic taken;
        logic mispred;
    } BrInfo;

    typedef enum logic {CLEAR, RUN} sched_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/bpred_update_fifo.sv
// Dual-push / single-pop BrInfo FIFO with flush; pushes land one cycle later, head is combinational.
// No internal backpressure: the caller never pushes more entries than DEPTH - count.
module bpred_update_fifo
    import bpred_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_a,
    input  BrInfo                    a_dat,
    input  logic                     push_b,
    input  BrInfo                    b_dat,
    input  logic                     pop,
    input  logic                     flush,
    output BrInfo                    head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    BrInfo          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr_b;
    logic [CW-1:0]  n_push;
    logic           do_pop;

    // A always takes the first free slot so a same-cycle pair stays in A, B order.
    assign wr_ptr_b = wr_ptr + PW'(push_a);
    assign n_push   = CW'(push_a) + CW'(push_b);
    assign do_pop   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_a) mem[wr_ptr]   <= a_dat;
            if (push_b) mem[wr_ptr_b] <= b_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + n_push - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bpred_update_scheduler.sv
// Merges execute (A) and commit (B) BrInfo updates into one registered predictor port; FIFO entry to upd in one cycle.
// Ready is a function of state, occupancy and priority only; table sweeps block both sources.
module bpred_update_scheduler
    import bpred_update_scheduler_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WIDTH_INDEX = BPRED_INDEX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  BrInfo                  brinfo_a,
    output logic                   a_ready,
    input  BrInfo                  brinfo_b,
    output logic                   b_ready,
    input  logic                   clear_req,
    output BrInfo                  upd,
    output logic                   clear_valid,
    output logic [WIDTH_INDEX-1:0] clear_index,
    output logic                   busy,
    output logic [15:0]            dropped
);
    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t           state;
    logic [WIDTH_INDEX-1:0] index;
    logic                   prio_b;
    logic [CW-1:0]          count;
    logic [CW-1:0]          free;
    logic                   run;
    logic                   push_a;
    logic                   push_b;
    logic                   pop;
    logic                   flush;
    BrInfo                  head;

    // With a single slot left only the source holding priority may take it.
    assign run     = (state == RUN);
    assign free    = CW'(DEPTH) - count;
    assign a_ready = run && ((free >= CW'(2)) || ((free == CW'(1)) && !prio_b));
    assign b_ready = run && ((free >= CW'(2)) || ((free == CW'(1)) && prio_b));
    assign push_a  = brinfo_a.valid && a_ready;
    assign push_b  = brinfo_b.valid && b_ready;
    assign pop     = run && !clear_req;
    assign flush   = run && clear_req;

    assign clear_valid = (state == CLEAR) && !reset;
    assign clear_index = index;
    assign busy        = (state == CLEAR);

    bpred_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_a (push_a),
        .a_dat  (brinfo_a),
        .push_b (push_b),
        .b_dat  (brinfo_b),
        .pop    (pop),
        .flush  (flush),
        .head   (head),
        .count  (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            index   <= '0;
            prio_b  <= 1'b0;
            dropped <= '0;
            upd     <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    upd <= '0;
                    if (clear_req) begin
                        index <= '0;
                    end else if (index == '1) begin
                        state <= RUN;
                        index <= '0;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                RUN: begin
                    if ((push_a || push_b) && (free == CW'(1)))
                        prio_b <= !prio_b;
                    if (clear_req) begin
                        // Entries accepted this cycle are flushed with the rest and counted.
                        state   <= CLEAR;
                        index   <= '0;
                        upd     <= '0;
                        dropped <= sat_add16(dropped, 16'(count) + 16'(push_a) + 16'(push_b));
                    end else begin
                        upd <= (count != '0) ? head : '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_bpred_update_scheduler.sv
// Directed bench for bpred_update_scheduler: vector table for arbitration/ordering, hand sequences for sweeps and reset.
module tb_bpred_update_scheduler;
    import bpred_update_scheduler_pkg::*;

    localparam int WI = 4;

    logic          clk = 1'b0;
    logic          reset;
    BrInfo         brinfo_a;
    BrInfo         brinfo_b;
    logic          a_ready;
    logic          b_ready;
    logic          clear_req;
    BrInfo         upd;
    logic          clear_valid;
    logic [WI-1:0] clear_index;
    logic          busy;
    logic [15:0]   dropped;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a_v;
        Addr  a_pc;
        logic b_v;
        Addr  b_pc;
        logic clr;
        logic e_a_rdy;
        logic e_b_rdy;
        logic e_upd_v;
        Addr  e_upd_pc;
        logic e_busy;
    } vec_t;

    vec_t vecs [11];

    bpred_update_scheduler #(.DEPTH(4), .WIDTH_INDEX(WI)) dut (
        .clk         (clk),
        .reset       (reset),
        .brinfo_a    (brinfo_a),
        .a_ready     (a_ready),
        .brinfo_b    (brinfo_b),
        .b_ready     (b_ready),
        .clear_req   (clear_req),
        .upd         (upd),
        .clear_valid (clear_valid),
        .clear_index (clear_index),
        .busy        (busy),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic BrInfo mk(input logic v, input Addr pc);
        BrInfo b;
        b = '0;
        b.valid = v;
        b.pc    = pc;
        return b;
    endfunction

    function automatic vec_t mkv(input logic av, input Addr apc, input logic bv, input Addr bpc,
                                 input logic clr, input logic ea, input logic eb, input logic ev,
                                 input Addr epc, input logic eby);
        vec_t v;
        v.a_v = av; v.a_pc = apc; v.b_v = bv; v.b_pc = bpc; v.clr = clr;
        v.e_a_rdy = ea; v.e_b_rdy = eb; v.e_upd_v = ev; v.e_upd_pc = epc; v.e_busy = eby;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        brinfo_a  = '0;
        brinfo_b  = '0;
        clear_req = 1'b0;

        //            A valid/pc          B valid/pc          clr   a_rdy b_rdy upd_v upd_pc      busy
        vecs[0]  = mkv(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0);
        vecs[1]  = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0);
        vecs[2]  = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        vecs[3]  = mkv(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        vecs[4]  = mkv(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0);
        vecs[5]  = mkv(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        vecs[6]  = mkv(1'b1, 32'h900, 1'b1, 32'h800, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
        vecs[7]  = mkv(1'b1, 32'h900, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0);
        vecs[8]  = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0);
        vecs[9]  = mkv(1'b1, 32'hA00, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 1'b0);
        vecs[10] = mkv(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upd_valid",   32'(upd.valid),   0);
        chk("rst_clear_valid", 32'(clear_valid), 0);
        chk("rst_a_ready",     32'(a_ready),     0);
        chk("rst_b_ready",     32'(b_ready),     0);
        chk("rst_busy",        32'(busy),        1);
        chk("rst_dropped",     32'(dropped),     0);

        // Power-up sweep of 16 entries
        reset = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk("sweep_valid", 32'(clear_valid), 1);
            chk("sweep_index", 32'(clear_index), 32'(k));
            step();
        end
        chk("run_busy",        32'(busy),        0);
        chk("run_a_ready",     32'(a_ready),     1);
        chk("run_b_ready",     32'(b_ready),     1);
        chk("run_clear_valid", 32'(clear_valid), 0);

        // Arbitration, ordering, steady count=3 and clear with in-flight entries
        for (int i = 0; i < 11; i++) begin
            brinfo_a  = mk(vecs[i].a_v, vecs[i].a_pc);
            brinfo_b  = mk(vecs[i].b_v, vecs[i].b_pc);
            clear_req = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready),   32'(vecs[i].e_a_rdy));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready),   32'(vecs[i].e_b_rdy));
            chk($sformatf("v%0d_upd_vld", i), 32'(upd.valid), 32'(vecs[i].e_upd_v));
            chk($sformatf("v%0d_busy", i),    32'(busy),      32'(vecs[i].e_busy));
            if (vecs[i].e_upd_v)
                chk($sformatf("v%0d_upd_pc", i), upd.pc, vecs[i].e_upd_pc);
            step();
        end
        brinfo_a  = '0;
        brinfo_b  = '0;
        clear_req = 1'b0;
        chk("flush_dropped", 32'(dropped),     3);
        chk("flush_sweep",   32'(clear_valid), 1);

        // Restart the sweep at index 7
        n = 0;
        while (clear_index != 4'd7 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("wait_index7_timeout", 32'(n), 0);
        clear_req = 1'b1;
        #1;
        chk("restart_at", 32'(clear_index), 7);
        step();
        clear_req = 1'b0;
        chk("restart_index", 32'(clear_index), 0);
        chk("restart_valid", 32'(clear_valid), 1);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk("restart_len",     32'(n),       16);
        chk("restart_a_ready", 32'(a_ready), 1);

        // Single update: no bypass, delivered after one cycle in the FIFO
        brinfo_a = mk(1'b1, 32'hB00);
        step();
        brinfo_a = '0;
        chk("single_nobypass", 32'(upd.valid), 0);
        step();
        chk("single_upd_vld", 32'(upd.valid), 1);
        chk("single_upd_pc",  upd.pc,         32'hB00);

        // Asynchronous reset mid-RUN with entries queued
        brinfo_a = mk(1'b1, 32'hC00);
        brinfo_b = mk(1'b1, 32'hD00);
        step();
        brinfo_a = '0;
        brinfo_b = '0;
        step();
        chk("pre_rst_upd_vld", 32'(upd.valid), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_upd_valid",   32'(upd.valid),   0);
        chk("arst_a_ready",     32'(a_ready),     0);
        chk("arst_b_ready",     32'(b_ready),     0);
        chk("arst_busy",        32'(busy),        1);
        chk("arst_clear_valid", 32'(clear_valid), 0);
        chk("arst_dropped",     32'(dropped),     0);
        step();
        reset = 1'b0;
        #1;
        chk("arst_sweep_valid", 32'(clear_valid), 1);
        chk("arst_sweep_index", 32'(clear_index), 0);
        repeat (3) step();
        chk("arst_sweep_index3", 32'(clear_index), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
